// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared constants and state encoding for the instruction fetch path.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

   localparam int unsigned  PC_STEP          = 4;
   localparam logic [31:0]  RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Brief    : Two-entry FIFO of {pc, instruction} with push/pop/flush and count.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic [ADDR_W-1:0] i_push_pc,
   input  logic [DATA_W-1:0] i_push_instr,
   input  logic              i_pop,
   input  logic              i_flush,
   output logic              o_head_valid,
   output logic [ADDR_W-1:0] o_head_pc,
   output logic [DATA_W-1:0] o_head_instr,
   output logic [1:0]        o_count
);

   logic [ADDR_W-1:0] r_pc    [2];
   logic [DATA_W-1:0] r_instr [2];
   logic              r_rd;
   logic              r_wr;
   logic [1:0]        r_count;
   logic              w_push;
   logic              w_pop;

   assign w_pop  = i_pop && (r_count != 2'd0);
   // A push into a full queue is only legal when the head leaves in the same cycle.
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) r_wr <= ~r_wr;
         if (w_pop)  r_rd <= ~r_rd;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc[r_wr]    <= i_push_pc;
         r_instr[r_wr] <= i_push_instr;
      end
   end

   assign o_head_valid = (r_count != 2'd0);
   assign o_head_pc    = o_head_valid ? r_pc[r_rd]    : '0;
   assign o_head_instr = o_head_valid ? r_instr[r_rd] : '0;
   assign o_count      = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_controller
//  Brief    : Owns the PC, issues one read per cycle to synchronous imem and
//             hands buffered {instruction, pc} to decode; handles redirect/halt.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_controller
   import fetch_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
   parameter int              Q_DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imemAddress,
   output logic              imemReadEnable,
   input  logic [DATA_W-1:0] imemInstruction,
   output logic              instrValid,
   output logic [DATA_W-1:0] instrData,
   output logic [ADDR_W-1:0] instrPc,
   input  logic              instrReady,
   input  logic              redirectValid,
   input  logic [ADDR_W-1:0] redirectPc,
   input  logic              haltReq,
   output logic              halted
);

   fetch_state_t      r_state;
   logic [ADDR_W-1:0] r_pc;
   logic              r_inflight;
   logic [ADDR_W-1:0] r_inflight_pc;

   logic              w_pop;
   logic              w_redirect;
   logic              w_issue;
   logic              w_push;
   logic [1:0]        w_count;
   logic [2:0]        w_occ;
   logic [ADDR_W-1:0] w_redirect_pc;

   assign w_pop         = instrValid && instrReady;
   assign w_redirect    = redirectValid && (r_state != IDLE);
   assign w_redirect_pc = redirectPc & ~ADDR_W'(3);

   // Credit: queued + inflight words after this cycle's pop must leave room for one more.
   assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue = (r_state == RUN) && !w_redirect && (w_occ < 3'(Q_DEPTH));

   // The word issued last cycle lands now unless a redirect is flushing the queue.
   assign w_push  = r_inflight && !w_redirect;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) r_inflight_pc <= r_pc;

         if (w_redirect) begin
            r_pc    <= w_redirect_pc;
            r_state <= RUN;
         end else begin
            if (w_issue) r_pc <= r_pc + ADDR_W'(PC_STEP);
            case (r_state)
               IDLE:    r_state <= RUN;
               RUN:     if (haltReq) r_state <= HALTED;
               HALTED:  r_state <= HALTED;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   fetch_queue #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_queue (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push       (w_push),
      .i_push_pc    (r_inflight_pc),
      .i_push_instr (imemInstruction),
      .i_pop        (w_pop),
      .i_flush      (w_redirect),
      .o_head_valid (instrValid),
      .o_head_pc    (instrPc),
      .o_head_instr (instrData),
      .o_count      (w_count)
   );

   assign imemAddress    = r_pc;
   assign imemReadEnable = w_issue;
   assign halted         = (r_state == HALTED);

endmodule
`default_nettype wire
